// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the
// shared comparator arbiter.
interface cmp_share_arbiter_if #(
    parameter int BITS = 8,
    parameter int N    = 4,
    parameter int IDW  = 2
);
    logic [N-1:0]      req_valid;
    logic [N*BITS-1:0] req_a;
    logic [N*BITS-1:0] req_b;
    logic [N*3-1:0]    req_op;
    logic [N-1:0]      req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic              resp_result;
    logic              resp_err;
    logic              busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_err, busy
    );

    // Requester / consumer side
    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_err, busy
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin front end that lets N requesters share a single unsigned
// magnitude/equality comparator. One comparison in flight at a time.
//
// state  | meaning
// IDLE   | waiting for a request; grants the round-robin winner
// EVAL   | comparator sees registered operands; result is captured
// RESP   | result held on resp_* until the consumer accepts it

module comparator #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic            o_eq,
    output logic            o_neq,
    output logic            o_lt,
    output logic            o_lte,
    output logic            o_gt,
    output logic            o_gte
);
    assign o_eq  = (i_a == i_b);
    assign o_neq = (i_a != i_b);
    assign o_lt  = (i_a <  i_b);
    assign o_lte = (i_a <= i_b);
    assign o_gt  = (i_a >  i_b);
    assign o_gte = (i_a >= i_b);
endmodule

module cmp_share_arbiter #(
    parameter int BITS = 8,
    parameter int N    = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_b;
    logic [2:0]      r_op;
    logic [IDW-1:0]  r_resp_id;
    logic            r_resp_result;
    logic            r_resp_err;
    logic            r_resp_valid;
    logic            r_busy;

    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_next_ptr;
    logic [N-1:0]    w_req_ready;
    logic [IDW:0]    w_sum;
    logic [IDW:0]    w_inc;
    logic [IDW-1:0]  w_idx;
    logic            w_eq, w_neq, w_lt, w_lte, w_gt, w_gte;
    logic            w_result;
    logic            w_err;

    comparator #(.BITS(BITS)) u_cmp (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_eq  (w_eq),
        .o_neq (w_neq),
        .o_lt  (w_lt),
        .o_lte (w_lte),
        .o_gt  (w_gt),
        .o_gte (w_gte)
    );

    // Winner search: scan offsets from far to near so the nearest set bit
    // at or above rr_ptr (wrapping modulo N) is the last one to land.
    always_comb begin
        w_any = |bus.req_valid;
        w_win = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end
            w_idx = w_sum[IDW-1:0];
            if (bus.req_valid[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // Pointer advances to the slot after the winner, wrapping at N.
    always_comb begin
        w_inc      = {1'b0, w_win} + (IDW+1)'(1);
        w_next_ptr = w_inc[IDW-1:0];
        if (w_inc >= (IDW+1)'(N)) begin
            w_next_ptr = '0;
        end
    end

    // Grant pulse: only in IDLE, only the winner.
    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            w_req_ready = N'(1) << w_win;
        end
    end

    // Relation decode from the shared comparator; codes 6/7 flag an error.
    always_comb begin
        w_result = 1'b0;
        w_err    = 1'b0;
        case (r_op)
            3'd0:    w_result = w_eq;
            3'd1:    w_result = w_neq;
            3'd2:    w_result = w_lt;
            3'd3:    w_result = w_lte;
            3'd4:    w_result = w_gt;
            3'd5:    w_result = w_gte;
            default: w_err    = 1'b1;
        endcase
    end

    // Sequencer: grant/latch, evaluate, hold result until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_resp_id     <= '0;
            r_resp_result <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a       <= bus.req_a[w_win*BITS +: BITS];
                        r_b       <= bus.req_b[w_win*BITS +: BITS];
                        r_op      <= bus.req_op[w_win*3 +: 3];
                        r_resp_id <= w_win;
                        r_rr_ptr  <= w_next_ptr;
                        r_busy    <= 1'b1;
                        r_state   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_resp_result <= w_result;
                    r_resp_err    <= w_err;
                    r_resp_valid  <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_err    = r_resp_err;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: expected grants and responses are
// queued by the stimulus and consumed by independent monitors.
module tb_cmp_share_arbiter;
    localparam int BITS = 8;
    localparam int N    = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           res;
        logic           err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic drop_en = 1'b1;

    resp_t exp_resp[$];
    int    exp_grant[$];

    cmp_share_arbiter_if #(.BITS(BITS), .N(N), .IDW(IDW)) bus ();

    cmp_share_arbiter #(.BITS(BITS), .N(N), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.req_a[i*BITS +: BITS] = a;
        bus.req_b[i*BITS +: BITS] = b;
        bus.req_op[i*3 +: 3]      = op;
        bus.req_valid[i]          = 1'b1;
    endtask

    task automatic push(input int gid, input logic res, input logic err);
        resp_t r;
        r.id  = IDW'(gid);
        r.res = res;
        r.err = err;
        exp_grant.push_back(gid);
        exp_resp.push_back(r);
    endtask

    task automatic wait_grant(input int i, input int budget, output int gcyc);
        gcyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) begin
                gcyc = cyc;
                return;
            end
        end
        fail($sformatf("grant_timeout_%0d", i));
    endtask

    task automatic wait_resp(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.resp_valid) return;
        end
        fail("resp_timeout");
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!bus.busy && !bus.resp_valid) return;
        end
        fail("idle_timeout");
    endtask

    // Response scoreboard and grant-order monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_resp.size() == 0) begin
                    fail("resp_unexpected");
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_id",     32'(bus.resp_id),     32'(e.id));
                    chk("resp_result", 32'(bus.resp_result), 32'(e.res));
                    chk("resp_err",    32'(bus.resp_err),    32'(e.err));
                end
            end
            if (bus.req_ready != '0) begin
                int gid;
                gid = -1;
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) gid = i;
                chk("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
                if (exp_grant.size() == 0) begin
                    fail("grant_unexpected");
                end else begin
                    chk("grant_id", 32'(gid), 32'(exp_grant.pop_front()));
                end
            end
        end
    end

    // Requester model: drop req_valid once granted (disabled for streaming).
    initial begin
        logic [N-1:0] w;
        forever begin
            @(negedge clk);
            w = bus.req_ready & bus.req_valid;
            if (w != '0) begin
                @(posedge clk);
                #2;
                if (drop_en) bus.req_valid = bus.req_valid & ~w;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, t0;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",   32'(bus.req_ready),   32'd0);
        chk("rst_resp_valid",  32'(bus.resp_valid),  32'd0);
        chk("rst_resp_id",     32'(bus.resp_id),     32'd0);
        chk("rst_resp_result", 32'(bus.resp_result), 32'd0);
        chk("rst_resp_err",    32'(bus.resp_err),    32'd0);
        chk("rst_busy",        32'(bus.busy),        32'd0);
        tick();
        rst_n = 1'b1;

        // Single request, lt: grant at T, response at T+2, gone at T+3
        tick();
        bus.resp_ready = 1'b1;
        push(2, 1'b1, 1'b0);
        set_req(2, 8'h05, 8'h09, 3'd2);
        t0 = cyc;
        wait_grant(2, 4, g);
        chk("single_grant_cycle", 32'(g), 32'(t0));
        chk("single_ready_vec",   32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("single_t1_valid", 32'(bus.resp_valid), 32'd0);
        chk("single_t1_busy",  32'(bus.busy),       32'd1);
        @(negedge clk);
        chk("single_t2_valid", 32'(bus.resp_valid), 32'd1);
        @(negedge clk);
        chk("single_t3_valid", 32'(bus.resp_valid), 32'd0);

        // Reset while holding a result in RESP
        tick();
        bus.resp_ready = 1'b0;
        exp_grant.push_back(1);
        set_req(1, 8'h03, 8'h04, 3'd0);
        wait_grant(1, 4, g);
        wait_resp(6);
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid_dropped", 32'(bus.resp_valid), 32'd0);
        chk("rst_busy_dropped",       32'(bus.busy),       32'd0);
        chk("rst_resp_id_cleared",    32'(bus.resp_id),    32'd0);
        tick();
        rst_n = 1'b1;
        exp_resp.delete();

        // All four streaming: grants 0,1,2,3,0 every third cycle
        drop_en = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(i % N, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) set_req(i, 8'h3C, 8'h3C, 3'd0);
        for (int k = 0; k <= 12; k++) begin
            logic [N-1:0] e;
            @(negedge clk);
            e = (k % 3 == 0) ? N'(1) << ((k / 3) % N) : '0;
            chk($sformatf("rr_ready_c%0d", k), 32'(bus.req_ready), 32'(e));
        end
        tick();
        bus.req_valid = '0;
        drop_en = 1'b1;
        wait_idle(20);

        // Backpressure: result stable, requester 3 starved until accept
        tick();
        bus.resp_ready = 1'b0;
        push(1, 1'b1, 1'b0);
        push(3, 1'b1, 1'b0);
        set_req(1, 8'hFF, 8'h00, 3'd4);
        set_req(3, 8'h01, 8'h02, 3'd2);
        wait_grant(1, 4, g);
        wait_resp(6);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("bp_valid",  32'(bus.resp_valid),  32'd1);
            chk("bp_result", 32'(bus.resp_result), 32'd1);
            chk("bp_id",     32'(bus.resp_id),     32'd1);
            chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.resp_ready = 1'b1;
        wait_grant(3, 6, g);
        wait_idle(8);

        // Invalid op then gte with equal operands
        tick();
        push(0, 1'b0, 1'b1);
        set_req(0, 8'h10, 8'h10, 3'd7);
        wait_grant(0, 4, g);
        wait_idle(8);
        tick();
        push(0, 1'b1, 1'b0);
        set_req(0, 8'h10, 8'h10, 3'd5);
        wait_grant(0, 4, g);
        wait_idle(8);

        // Wrap after grant to 3, then withdraw requester 2
        tick();
        push(3, 1'b1, 1'b0);
        set_req(3, 8'h07, 8'h07, 3'd3);
        wait_grant(3, 4, g);
        tick();
        push(0, 1'b0, 1'b0);
        set_req(0, 8'h01, 8'h02, 3'd4);
        set_req(2, 8'h09, 8'h01, 3'd1);
        wait_grant(0, 8, g);
        tick();
        bus.req_valid[2] = 1'b0;
        wait_resp(6);
        @(negedge clk);
        chk("withdraw_no_grant", 32'(bus.req_ready), 32'd0);
        chk("withdraw_idle",     32'(bus.busy),      32'd0);
        @(negedge clk);
        chk("withdraw_no_grant2", 32'(bus.req_ready), 32'd0);
        chk("withdraw_idle2",     32'(bus.busy),      32'd0);

        repeat (3) @(negedge clk);
        chk("resp_queue_drained",  32'(exp_resp.size()),  32'd0);
        chk("grant_queue_drained", 32'(exp_grant.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one instance of the team's `comparator` datapath between N requesters.
- Each requester submits an operand pair and a relation code. A round-robin arbiter grants one request at a time.
- A 3-state FSM registers the operands, evaluates the relation and holds the 1-bit result until the consumer accepts it.
- Sits between the control units that need magnitude/equality tests and the single comparator, so the ALU area keeps one comparator.

Parameters:
- BITS, 8, operand width passed to the comparator instance.
- N, 4, number of requesters (2..16).
- IDW, 2, width of the requester index; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  N  bit i = requester i has a request pending.
- req_a  input  N*BITS  operand A, requester i at bits [i*BITS +: BITS].
- req_b  input  N*BITS  operand B, same packing.
- req_op  input  N*3  relation code, requester i at [i*3 +: 3].
- req_ready  output  N  one-hot grant pulse; request i accepted this cycle.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  IDW  index of the requester that owns the result.
- resp_result  output  1  relation outcome.
- resp_err  output  1  op code was invalid.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge) overrides everything:
  - FSM goes to IDLE; round-robin pointer rr_ptr goes to 0.
  - Operand and op registers clear to 0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, busy=0.
  - An in-flight result is discarded and not replayed.
- Op codes:
  - 0 = eq, 1 = neq, 2 = lt, 3 = lte, 4 = gt, 5 = gte, taken from the comparator outputs of the same name.
  - Comparison is unsigned.
  - Codes 6 and 7 are invalid: resp_result=0, resp_err=1.
- Handshake: a request is transferred when req_valid[i]=1 and req_ready[i]=1 in the same cycle.
  - req_ready is combinational from state and req_valid. It is asserted only in IDLE, only for the winner, and is never high for more than one bit.
  - A requester holds req_valid and its operands stable until granted. Dropping req_valid before the grant is legal and withdraws the request.
- FSM states: IDLE, EVAL, RESP.
  - IDLE: if any req_valid bit is set, pick the winner W = first set bit scanning from rr_ptr upward and wrapping modulo N. Then assert req_ready[W] for that cycle, latch req_a/req_b/req_op of W into registers, latch resp_id=W, set rr_ptr=(W+1) mod N and go to EVAL. Otherwise stay in IDLE, leaving rr_ptr unchanged.
  - EVAL: the comparator sees the registered operands. Register resp_result and resp_err from the op decode, then go to RESP.
  - RESP: resp_valid=1. resp_id, resp_result and resp_err stay stable until resp_ready=1. When resp_ready=1, go to IDLE with resp_valid=0 on the next cycle. resp_ready is ignored when resp_valid=0.
- Latency and throughput:
  - Grant cycle T, resp_valid first high at T+2.
  - With resp_ready held at 1, the next grant occurs at T+3, so peak throughput is one comparison per 3 cycles.
  - No grant is issued while in EVAL or RESP; requests wait.
- busy=1 in EVAL and RESP, 0 in IDLE.
- Fairness:
  - With all N requesters continuously valid, grants rotate 0,1,…,N-1,0,…
  - No requester waits more than N-1 foreign grants.
- rr_ptr wraps from N-1 to 0. With N not a power of two, only indices below N are ever granted.
- All outputs are registered except req_ready.

Test Plan:
- Reset with BITS=8, N=4, all inputs 0 → all outputs 0. Then pulse rst_n=0 while in RESP holding a result → the next cycle shows resp_valid=0, busy=0, and rr_ptr restarts at 0.
- Single request, requester 2, a=8'h05, b=8'h09, op=2 (lt), resp_ready=1 → req_ready=4'b0100 at T, resp_valid=1 with resp_id=2, resp_result=1, resp_err=0 at T+2, and resp_valid=0 at T+3.
- All four valid continuously, each with a=b=8'h3C, op=0 (eq), resp_ready=1 → grants 0,1,2,3,0 at cycles 0,3,6,9,12, every resp_result=1.
- Backpressure: requester 1, a=8'hFF, b=8'h00, op=4 (gt), resp_ready=0 for 5 cycles → resp_valid stays 1 with resp_result=1 and resp_id=1 stable throughout, and requester 3, held valid all the while, gets no grant before resp_ready=1.
- Invalid op: requester 0, a=8'h10, b=8'h10, op=7 → resp_result=0, resp_err=1. Then op=5 (gte) with the same operands → resp_result=1, resp_err=0.
- Pointer wrap and withdraw: after a grant to 3, requesters 0 and 2 are valid → 0 wins first. Drop req_valid[2] while 0 is being serviced → the following IDLE cycle issues no grant and the FSM stays in IDLE.
